// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host sequencer: sdc_controller register map,
// ISR bit positions, sequencer states and the command byte-write helper.
package sd_host_pkg;

    localparam logic [6:0] REG_ARG0        = 7'h00;
    localparam logic [6:0] REG_ARG1        = 7'h01;
    localparam logic [6:0] REG_ARG2        = 7'h02;
    localparam logic [6:0] REG_ARG3        = 7'h03;
    localparam logic [6:0] REG_CMD_SETTING = 7'h04;
    localparam logic [6:0] REG_CMD_INDEX   = 7'h05;
    localparam logic [6:0] REG_CMD_ISR     = 7'h0C;
    localparam logic [6:0] REG_CLK_DIV     = 7'h24;
    localparam logic [6:0] REG_DATA_ISR    = 7'h48;

    localparam int ISR_COMPLETE_BIT = 0;
    localparam int ISR_ERROR_BIT    = 1;

    localparam logic [7:0] CMD17_SETTING = 8'b0011_1101;
    localparam logic [2:0] CMD_LAST_STEP = 3'd5;

    typedef enum logic [3:0] {
        ST_RESET_WAIT,
        ST_INIT_DIV,
        ST_CMD0,
        ST_GAP0,
        ST_CMD7,
        ST_WAIT7,
        ST_CLR7,
        ST_IDLE,
        ST_RD_CLR,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RD_FIN
    } seq_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } reg_write_t;

    // A command is six byte writes; the final ARG0 write launches it.
    function automatic reg_write_t cmd_write(input logic [7:0]  idx,
                                             input logic [7:0]  setting,
                                             input logic [31:0] arg,
                                             input logic [2:0]  step);
        reg_write_t w;
        case (step)
            3'd0:    w = '{addr: REG_CMD_INDEX,   data: idx};
            3'd1:    w = '{addr: REG_CMD_SETTING, data: setting};
            3'd2:    w = '{addr: REG_ARG3,        data: arg[31:24]};
            3'd3:    w = '{addr: REG_ARG2,        data: arg[23:16]};
            3'd4:    w = '{addr: REG_ARG1,        data: arg[15:8]};
            default: w = '{addr: REG_ARG0,        data: arg[7:0]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sd_host_sequencer_if.sv
// Read-request handshake plus the sdc_controller register bus driven by the sequencer.
interface sd_host_sequencer_if;
    logic        start;
    logic [31:0] blk_addr;
    logic        ready;
    logic        done;
    logic        error;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic [7:0]  reg_rdata;

    modport master (
        input  start, blk_addr, reg_rdata,
        output ready, done, error, reg_addr, reg_wdata, reg_we
    );

    modport slave (
        output start, blk_addr, reg_rdata,
        input  ready, done, error, reg_addr, reg_wdata, reg_we
    );
endinterface

// File: rtl/sd_reg_writer.sv
// Three-cycle register write engine: address/data cycle, strobe cycle, idle cycle.
module sd_reg_writer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       ack,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we
);
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE} wr_phase_t;

    wr_phase_t phase;

    // ack is raised during the strobe cycle so the caller can present the next
    // write while the bus idles, keeping back-to-back writes at one per 3 clocks.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase     <= W_IDLE;
            ack       <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
        end else begin
            ack    <= 1'b0;
            reg_we <= 1'b0;
            case (phase)
                W_IDLE: begin
                    if (req) begin
                        reg_addr  <= addr;
                        reg_wdata <= data;
                        phase     <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    reg_we <= 1'b1;
                    ack    <= 1'b1;
                    phase  <= W_STROBE;
                end
                default: phase <= W_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/sd_host_sequencer.sv
// Initialises the SD card through sdc_controller registers (clock divider, CMD0, CMD7)
// and then serves single-block CMD17 reads requested by the streaming logic.
module sd_host_sequencer
    import sd_host_pkg::*;
#(
    parameter logic [7:0]  CLK_DIV      = 8'd2,
    parameter logic [15:0] RCA          = 16'h0013,
    parameter int unsigned POLL_TIMEOUT = 65535,
    parameter int unsigned CMD_GAP      = 1000
) (
    input logic                  clk,
    input logic                  rstn,
    sd_host_sequencer_if.master  bus
);
    localparam logic [16:0] RESET_LAST  = 17'd15;
    localparam logic [16:0] GAP_LAST    = 17'(CMD_GAP - 1);
    localparam logic [16:0] TIMEOUT_MAX = 17'(POLL_TIMEOUT);

    seq_state_t  state;
    logic [2:0]  step;
    logic [16:0] timer;
    logic [31:0] blk_addr_q;
    logic        rd_ok;
    logic        polling;
    logic [6:0]  poll_addr;

    reg_write_t  wr;
    logic        wr_req;
    logic        wr_last;
    logic        wr_ack;
    logic        wr_done;
    logic [6:0]  wr_reg_addr;
    logic [7:0]  wr_reg_wdata;
    logic        wr_reg_we;
    logic        isr_complete;
    logic        isr_error;

    always_comb begin
        wr      = '{addr: 7'h00, data: 8'h00};
        wr_req  = 1'b1;
        wr_last = 1'b1;
        case (state)
            ST_INIT_DIV: wr = '{addr: REG_CLK_DIV, data: CLK_DIV};
            ST_CMD0: begin
                wr      = cmd_write(8'd0, 8'h00, 32'h0, step);
                wr_last = (step == CMD_LAST_STEP);
            end
            ST_CMD7: begin
                wr      = cmd_write(8'd7, 8'h00, {RCA, 16'h0000}, step);
                wr_last = (step == CMD_LAST_STEP);
            end
            ST_CLR7:              wr = '{addr: REG_CMD_ISR, data: 8'h00};
            ST_RD_CLR, ST_RD_FIN: wr = '{addr: REG_DATA_ISR, data: 8'h00};
            ST_RD_CMD: begin
                wr      = cmd_write(8'd17, CMD17_SETTING, blk_addr_q, step);
                wr_last = (step == CMD_LAST_STEP);
            end
            default: wr_req = 1'b0;
        endcase
    end

    assign wr_done      = wr_req && wr_ack && wr_last;
    assign isr_complete = bus.reg_rdata[ISR_COMPLETE_BIT];
    assign isr_error    = bus.reg_rdata[ISR_ERROR_BIT];

    sd_reg_writer u_writer (
        .clk       (clk),
        .rstn      (rstn),
        .req       (wr_req),
        .addr      (wr.addr),
        .data      (wr.data),
        .ack       (wr_ack),
        .reg_addr  (wr_reg_addr),
        .reg_wdata (wr_reg_wdata),
        .reg_we    (wr_reg_we)
    );

    // While polling, the ISR address owns the bus; the writer is idle then.
    assign bus.reg_addr  = polling ? poll_addr : wr_reg_addr;
    assign bus.reg_wdata = wr_reg_wdata;
    assign bus.reg_we    = wr_reg_we;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_RESET_WAIT;
            step       <= '0;
            timer      <= '0;
            blk_addr_q <= '0;
            rd_ok      <= 1'b0;
            polling    <= 1'b0;
            poll_addr  <= '0;
            bus.ready  <= 1'b0;
            bus.done   <= 1'b0;
            bus.error  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (wr_req) begin
                timer <= '0;
                if (wr_ack) step <= wr_last ? 3'd0 : step + 3'd1;
            end
            case (state)
                ST_RESET_WAIT: begin
                    if (timer == RESET_LAST) state <= ST_INIT_DIV;
                    else                     timer <= timer + 17'd1;
                end
                ST_INIT_DIV: if (wr_done) state <= ST_CMD0;
                ST_CMD0:     if (wr_done) state <= ST_GAP0;
                ST_GAP0: begin
                    if (timer == GAP_LAST) state <= ST_CMD7;
                    else                   timer <= timer + 17'd1;
                end
                ST_CMD7: begin
                    if (wr_done) begin
                        state     <= ST_WAIT7;
                        polling   <= 1'b1;
                        poll_addr <= REG_CMD_ISR;
                    end
                end
                ST_WAIT7: begin
                    if (isr_error || timer == TIMEOUT_MAX) begin
                        bus.error <= 1'b1;
                        bus.ready <= 1'b1;
                        polling   <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (isr_complete) begin
                        polling <= 1'b0;
                        state   <= ST_CLR7;
                    end else begin
                        timer <= timer + 17'd1;
                    end
                end
                ST_CLR7: begin
                    if (wr_done) begin
                        bus.ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.start) begin
                        blk_addr_q <= bus.blk_addr;
                        bus.error  <= 1'b0;
                        bus.ready  <= 1'b0;
                        state      <= ST_RD_CLR;
                    end
                end
                ST_RD_CLR: if (wr_done) state <= ST_RD_CMD;
                ST_RD_CMD: begin
                    if (wr_done) begin
                        state     <= ST_RD_WAIT;
                        polling   <= 1'b1;
                        poll_addr <= REG_DATA_ISR;
                    end
                end
                ST_RD_WAIT: begin
                    if (isr_error || timer == TIMEOUT_MAX) begin
                        bus.error <= 1'b1;
                        rd_ok     <= 1'b0;
                        polling   <= 1'b0;
                        state     <= ST_RD_FIN;
                    end else if (isr_complete) begin
                        rd_ok   <= 1'b1;
                        polling <= 1'b0;
                        state   <= ST_RD_FIN;
                    end else begin
                        timer <= timer + 17'd1;
                    end
                end
                ST_RD_FIN: begin
                    if (wr_done) begin
                        bus.ready <= 1'b1;
                        bus.done  <= rd_ok;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_RESET_WAIT;
            endcase
        end
    end
endmodule
